// File: rtl/ub_row_reader_if.sv
// ---------------------------------------------------------------------------
// ub_row_reader_if
// Purpose : bundles the command, unified-buffer read port and output stream
//           signals of ub_row_reader into one interface.
// Signals : start/base_addr/row_count  command from the controller
//           busy/done                  command status
//           enb/addrb/doutb            unified-buffer read port
//           m_valid/m_ready/m_data/m_last  row stream toward the array skew
// Modports: master = controller/buffer/consumer side, slave = the reader.
// ---------------------------------------------------------------------------
interface ub_row_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   row_count;
    logic                  busy;
    logic                  done;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output start, base_addr, row_count, doutb, m_ready,
        input  busy, done, enb, addrb, m_valid, m_data, m_last
    );

    modport slave (
        input  start, base_addr, row_count, doutb, m_ready,
        output busy, done, enb, addrb, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ub_row_reader.sv
// ---------------------------------------------------------------------------
// ub_row_reader
// Purpose : read-side sequencer for the 256 x 128-bit unified buffer. A start
//           command streams row_count contiguous rows (address wraps modulo
//           2^ADDR_WIDTH) out of the buffer read port onto a valid/ready
//           stream. A 2-entry register queue absorbs the one-cycle read
//           latency so back-pressure never drops or duplicates a row.
// Ports   : clk     single clock, rising edge
//           rst     asynchronous active-high reset
//           io_bus  ub_row_reader_if.slave (command, buffer port, stream)
// ---------------------------------------------------------------------------
module ub_row_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128
) (
    input  logic           clk,
    input  logic           rst,
    ub_row_reader_if.slave io_bus
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_next;
    logic [ADDR_WIDTH-1:0] r_addrb, w_addrb_next;
    logic [CW-1:0]         r_issue_left, w_issue_left_next;
    logic [CW-1:0]         r_pop_left, w_pop_left_next;
    logic                  r_enb, w_enb_next;

    logic [DATA_WIDTH-1:0] r_q_head;
    logic [DATA_WIDTH-1:0] r_q_tail;
    logic [1:0]            r_q_count;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_space;
    logic                  w_done;

    assign w_valid = (r_q_count != 2'd0);
    assign w_pop   = w_valid & io_bus.m_ready;
    // r_enb high means a read is on the buffer port this cycle; its data is
    // captured into the queue on the closing edge, so r_enb is the in-flight flag.
    assign w_push  = r_enb;

    // Occupancy the queue will have after this edge. A read issued now lands
    // one edge later, so it may only go out if that occupancy leaves a slot.
    assign w_occ   = {1'b0, r_q_count} + {2'b00, r_enb} - {2'b00, w_pop};
    assign w_space = (w_occ < 3'd2);

    assign w_done  = (r_state == S_DRAIN) && (r_pop_left == '0) && !r_enb;

    // Next-state and next-register logic
    always_comb begin
        w_state_next      = r_state;
        w_enb_next        = 1'b0;
        w_addrb_next      = r_addrb;
        w_rd_addr_next    = r_rd_addr;
        w_issue_left_next = r_issue_left;
        w_pop_left_next   = w_pop ? (r_pop_left - CW'(1)) : r_pop_left;

        unique case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_pop_left_next = io_bus.row_count;
                    if (io_bus.row_count == '0) begin
                        w_issue_left_next = '0;
                        w_state_next      = S_DRAIN;
                    end else begin
                        // The queue is empty in IDLE, so the first read
                        // can go out on the accepting edge.
                        w_enb_next        = 1'b1;
                        w_addrb_next      = io_bus.base_addr;
                        w_rd_addr_next    = io_bus.base_addr + ADDR_WIDTH'(1);
                        w_issue_left_next = io_bus.row_count - CW'(1);
                        w_state_next      = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if ((r_issue_left != '0) && w_space) begin
                    w_enb_next        = 1'b1;
                    w_addrb_next      = r_rd_addr;
                    w_rd_addr_next    = r_rd_addr + ADDR_WIDTH'(1);
                    w_issue_left_next = r_issue_left - CW'(1);
                end
                if (w_issue_left_next == '0) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_addrb      <= '0;
            r_issue_left <= '0;
            r_pop_left   <= '0;
            r_enb        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_rd_addr    <= w_rd_addr_next;
            r_addrb      <= w_addrb_next;
            r_issue_left <= w_issue_left_next;
            r_pop_left   <= w_pop_left_next;
            r_enb        <= w_enb_next;
        end
    end

    // 2-entry register queue; head drives the stream directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_head  <= '0;
            r_q_tail  <= '0;
            r_q_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_q_count == 2'd0) begin
                        r_q_head <= io_bus.doutb;
                    end else begin
                        r_q_tail <= io_bus.doutb;
                    end
                    r_q_count <= r_q_count + 2'd1;
                end
                2'b01: begin
                    r_q_head  <= r_q_tail;
                    r_q_count <= r_q_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new row goes behind whatever
                    // remains after the pop.
                    if (r_q_count == 2'd1) begin
                        r_q_head <= io_bus.doutb;
                    end else begin
                        r_q_head <= r_q_tail;
                        r_q_tail <= io_bus.doutb;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.busy    = (r_state != S_IDLE) && !w_done;
    assign io_bus.done    = w_done;
    assign io_bus.enb     = r_enb;
    assign io_bus.addrb   = r_addrb;
    assign io_bus.m_valid = w_valid;
    assign io_bus.m_data  = r_q_head;
    assign io_bus.m_last  = w_valid && (r_pop_left == CW'(1));

endmodule

// File: tb/tb_ub_row_reader.sv
// ---------------------------------------------------------------------------
// tb_ub_row_reader
// Self-checking bench for ub_row_reader: a behavioural buffer memory drives
// doutb, and each command is checked against the rows it should deliver
// (mem[(base+i) mod 256] in order), the addresses it should read, the
// handshake rules and the cycle timing.
// ---------------------------------------------------------------------------
module tb_ub_row_reader;
    localparam int AW = 8;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [0:255];

    ub_row_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ub_row_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Buffer model: samples the address on the falling edge, data is then
    // stable for the following rising edge.
    always @(negedge clk) begin
        if (bus.enb) begin
            bus.doutb <= mem[bus.addrb];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_and_check();
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_busy",    {127'd0, bus.busy},    '0);
        check("rst_done",    {127'd0, bus.done},    '0);
        check("rst_enb",     {127'd0, bus.enb},     '0);
        check("rst_addrb",   {120'd0, bus.addrb},   '0);
        check("rst_m_valid", {127'd0, bus.m_valid}, '0);
        check("rst_m_data",  bus.m_data,            '0);
        check("rst_m_last",  {127'd0, bus.m_last},  '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one command. rand_ready: random back-pressure with 5-cycle stalls.
    // restart: re-pulse start mid-command. abort_after >= 0: reset once that
    // many rows have been accepted.
    task automatic run_cmd(input logic [7:0] base, input int count, input bit rand_ready,
                           input bit restart, input int abort_after);
        int issued = 0;
        int popped = 0;
        int first_enb = 0;
        int first_valid = 0;
        int done_cyc = 0;
        int stall_left = 0;
        int budget;
        bit done_seen = 0;
        bit exp_done;
        bit prev_stall = 0;
        logic [DW-1:0] prev_data = '0;
        logic [7:0] exp_addr;

        budget = 20 * count + 20;
        exp_addr = base;
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.row_count = 9'(count);
        bus.m_ready = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (abort_after >= 0 && popped == abort_after) begin
                reset_and_check();
                $display("cmd base=%02h count=%0d aborted by reset after %0d rows", base, count, popped);
                return;
            end
            bus.start = 1'b0;
            if (restart && cyc == 3) begin
                bus.start = 1'b1;
                bus.base_addr = base + 8'h40;
                bus.row_count = 9'd3;
            end else begin
                bus.base_addr = 8'($urandom);
                bus.row_count = 9'($urandom);
            end
            if (!rand_ready) begin
                bus.m_ready = 1'b1;
            end else if (stall_left > 0) begin
                bus.m_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.m_ready = 1'b0;
                stall_left = 4;
            end else begin
                bus.m_ready = 1'($urandom);
            end

            exp_done = (popped == count);
            check("done", {127'd0, bus.done}, {127'd0, exp_done});
            check("busy", {127'd0, bus.busy}, {127'd0, !exp_done});

            if (bus.enb) begin
                if (first_enb == 0) first_enb = cyc;
                check("addrb", {120'd0, bus.addrb}, {120'd0, exp_addr});
                exp_addr++;
                issued++;
            end
            check("occupancy", {127'd0, (issued - popped) <= 2}, 128'd1);

            if (prev_stall) begin
                check("stall_valid", {127'd0, bus.m_valid}, 128'd1);
                check("stall_data", bus.m_data, prev_data);
            end
            if (bus.m_valid) begin
                if (first_valid == 0) first_valid = cyc;
                check("m_last", {127'd0, bus.m_last}, {127'd0, popped == count - 1});
                if (bus.m_ready) begin
                    check("m_data", bus.m_data, mem[8'(int'(base) + popped)]);
                    popped++;
                end
            end else begin
                check("m_last_idle", {127'd0, bus.m_last}, '0);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;

            if (bus.done) begin
                done_cyc = cyc;
                done_seen = 1;
                break;
            end
        end
        check("timeout", {127'd0, done_seen}, 128'd1);
        check("rows", 128'(popped), 128'(count));
        check("issued", 128'(issued), 128'(count));
        if (!rand_ready) begin
            check("first_enb_cycle", 128'(first_enb), (count > 0) ? 128'd1 : 128'd0);
            check("first_valid_cycle", 128'(first_valid), (count > 0) ? 128'd2 : 128'd0);
            check("done_cycle", 128'(done_cyc), (count > 0) ? 128'(count + 2) : 128'd1);
        end
        $display("cmd base=%02h count=%0d rows=%0d done_cycle=%0d", base, count, popped, done_cyc);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.row_count = '0;
        bus.m_ready = 1'b0;
        bus.doutb = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end

        repeat (2) @(negedge clk);
        reset_and_check();

        run_cmd(8'h10, 4, 0, 0, -1);        // basic stream
        run_cmd(8'hFE, 4, 0, 0, -1);        // address wrap
        run_cmd(8'h30, 8, 1, 0, -1);        // back-pressure
        run_cmd(8'hA5, 8, 1, 0, -1);
        run_cmd(8'hFC, 8, 1, 0, -1);
        run_cmd(8'h00, 0, 0, 0, -1);        // zero count
        run_cmd(8'h80, 256, 0, 0, -1);      // full count
        run_cmd(8'h50, 6, 0, 1, -1);        // ignored restart
        run_cmd(8'h60, 3, 0, 0, -1);        // start after done accepted
        run_cmd(8'h70, 10, 0, 0, 3);        // reset mid-command
        run_cmd(8'h20, 2, 0, 0, -1);        // clean stream after reset
        for (int k = 0; k < 6; k++) begin
            run_cmd(8'($urandom), $urandom_range(1, 20), 1, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ub_row_reader.md
# ub_row_reader

Read-side sequencer for the 256 x 128-bit unified buffer. On a start command it streams a contiguous block of rows out of the buffer's read port (enb/addrb/doutb) and presents them on a valid/ready stream toward the systolic-array input skew logic. A 2-entry output queue absorbs the buffer's one-cycle read latency so that back-pressure never drops or duplicates a row.

## Interface
- ADDR_WIDTH, 8, buffer address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 128, row width (16 lanes x 8 b)
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command pulse; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first row address, latched on accepted start
- row_count  in  ADDR_WIDTH+1  rows to read (0..256), latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last row has been handed off
- enb  out  1  buffer read enable
- addrb  out  ADDR_WIDTH  buffer read address
- doutb  in  DATA_WIDTH  buffer read data, valid on the rising edge after the cycle enb was high
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  row data
- m_last  out  1  high with the final row of the command

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: busy=0. start=1 latches base_addr into rd_addr and row_count into issue_left and pop_left. If row_count==0, go to DRAIN (no reads). Otherwise go to RUN.
- RUN: issue a read (enb=1, addrb=rd_addr) in any cycle where issue_left>0 and (queue_count + inflight - pop) < 2, with pop = m_valid & m_ready. Each issue increments rd_addr modulo 2^ADDR_WIDTH (0xFF wraps to 0x00) and decrements issue_left. When issue_left reaches 0, go to DRAIN.
- inflight is 1 in the cycle after an issue. On that rising edge doutb is pushed into the queue tail.
- The queue is a 2-entry register FIFO. m_data and m_valid come from the head register, not from doutb combinationally. Simultaneous push and pop are allowed in the same edge.
- m_last = m_valid & (pop_left==1). Each pop decrements pop_left.
- DRAIN: when pop_left==0 and inflight==0, pulse done for one cycle and return to IDLE. busy is cleared in the same cycle done is high.
- start while busy is ignored. Latched inputs are not re-sampled.
- enb is 0 whenever no read is issued, so the buffer is not read needlessly.
- Reset, asserted at any time including mid-command: state=IDLE; queue, inflight, and counters cleared. Outputs are busy=0, done=0, enb=0, addrb=0, m_valid=0, m_data=0, m_last=0. Rows already in flight are discarded.

## Timing
- Cycle 0: start sampled. Cycle 1: first enb=1, addrb=base_addr. Cycle 2: m_valid=1 with row base_addr.
- With m_ready held high: one row per cycle. Rows are valid in cycles 2..N+1; done pulses in cycle N+2; busy is high in cycles 1..N+1.
- row_count==0: done pulses in cycle 1 and busy stays 0. No enb and no m_valid.
- Back-pressure: m_valid and m_data hold stable while m_ready=0. At most 2 rows are buffered plus 0 in flight. Issuing resumes the cycle a pop frees space.
- The buffer samples addrb on its half-cycle edge, which gives the one-rising-edge read latency. addrb and enb are registered outputs.

## Test plan
- Basic stream: base=0x10, count=4, m_ready=1 -> addrb 0x10..0x13 in cycles 1-4; m_data equals preloaded rows in cycles 2-5; m_last in cycle 5; done in cycle 6.
- Wrap: base=0xFE, count=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 in order. Data matches those rows.
- Back-pressure: count=8 with m_ready toggling at random, including 5-cycle stalls -> all 8 rows arrive exactly once, in order. Never more than 2 queued. m_data stable while stalled.
- Zero/full count: count=0 -> done only in cycle 1, no enb. Count=256, base=0x80 -> 256 rows, m_last on row 0x7F, done after.
- Ignored start: start re-pulsed mid-command with different base -> no effect on the stream. A subsequent start after done is accepted.
- Reset mid-op: rst asserted after 3 of 10 rows -> all outputs 0 immediately. A new start with count=2 then streams 2 correct rows with no stale data.
